// File: rtl/morse_pkg.sv
// Shared definitions for the morse dispatch path: supported character codes,
// the code-legality check used at write time, and the dispatch FSM states.
package morse_pkg;

  localparam logic [7:0] CODE_STOP = 8'hFF;
  localparam logic [7:0] CODE_A    = 8'd65;
  localparam logic [7:0] CODE_B    = 8'd66;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_FIN,
    ST_GAP,
    ST_DONE,
    ST_ABORT
  } dispatch_state_t;

  // Digits 0-9, A, B and STOP are the only codes morse_send can encode.
  function automatic logic is_supported(input logic [7:0] code);
    return (code <= 8'd9) || (code == CODE_A) || (code == CODE_B) || (code == CODE_STOP);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous 8-bit character FIFO with read-ahead head, flush and occupancy.
// Push/pop take effect on the clock edge; a push while full is dropped even if a pop coincides.
module char_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/morse_dispatch.sv
// Queues character codes and plays them one at a time into morse_send, with a
// finish handshake, timeout, inter-character gap and clear-driven abort.
module morse_dispatch
  import morse_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int START_LEN  = 2,
  parameter int GAP_CYCLES = 1000,
  parameter int TIMEOUT    = 2**24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       send,
  input  logic                       clear,
  output logic [7:0]                 val,
  output logic                       start_flag,
  input  logic                       finish_flag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_err,
  output logic                       err
);

  localparam int MASK_LEN = START_LEN + 2;
  localparam int BIG_A    = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_MAX  = (BIG_A > MASK_LEN) ? BIG_A : MASK_LEN;
  localparam int CW       = $clog2(CNT_MAX + 1);

  dispatch_state_t state;
  dispatch_state_t state_nxt;
  logic [CW-1:0]   cnt;
  logic [7:0]      head;
  logic            fin_meta;
  logic            fin_sync;
  logic            wr_ok;
  logic            pop;
  logic            fin_seen;
  logic            timeout_hit;
  logic            start_nxt;

  assign wr_ok       = wr_en && !clear && !full && is_supported(wr_data);
  assign pop         = (state == ST_LOAD) && !clear;
  // finish_flag is still high from the previous character until start_flag propagates.
  assign fin_seen    = fin_sync && (cnt >= CW'(MASK_LEN));
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  char_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (wr_ok),
    .push_data (wr_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = (state == ST_IDLE) ? ST_IDLE : ST_ABORT;
    end else begin
      case (state)
        ST_IDLE:     if (send) state_nxt = empty ? ST_DONE : ST_LOAD;
        ST_LOAD:     state_nxt = ST_START;
        ST_START:    if (cnt == CW'(START_LEN - 1)) state_nxt = ST_WAIT_FIN;
        ST_WAIT_FIN: if (fin_seen || timeout_hit) state_nxt = ST_GAP;
        ST_GAP:      if (cnt == CW'(GAP_CYCLES - 1)) state_nxt = empty ? ST_DONE : ST_LOAD;
        ST_DONE:     state_nxt = ST_IDLE;
        ST_ABORT:    if (cnt == CW'(START_LEN - 1)) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    start_nxt = (state == ST_START) || (state == ST_ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fin_meta   <= 1'b0;
      fin_sync   <= 1'b0;
      cnt        <= '0;
      val        <= CODE_STOP;
      start_flag <= 1'b0;
      err        <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      fin_meta   <= finish_flag;
      fin_sync   <= fin_meta;
      cnt        <= (clear || (state_nxt != state)) ? '0 : cnt + CW'(1);
      start_flag <= start_nxt;
      err        <= !clear && (state == ST_WAIT_FIN) && !fin_seen && timeout_hit;
      wr_err     <= wr_en && !clear && !wr_ok;
      if (clear && busy) val <= CODE_STOP;
      else if (pop)      val <= head;
    end
  end

endmodule

// File: tb/tb_morse_dispatch.sv
// Bench for morse_dispatch: a morse_send stand-in answers each start pulse, and a
// scoreboard queue of expected codes is consumed as start_flag pulses appear.
module tb_morse_dispatch;

  localparam int DEPTH      = 16;
  localparam int START_LEN  = 2;
  localparam int GAP_CYCLES = 20;
  localparam int TIMEOUT    = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       send;
  logic       clear;
  logic [7:0] val;
  logic       start_flag;
  logic       finish_flag;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic       wr_err;
  logic       err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int start_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int play_len  = 30;
  bit hold_low  = 1'b0;

  morse_dispatch #(
    .DEPTH(DEPTH), .START_LEN(START_LEN), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .send(send), .clear(clear),
    .val(val), .start_flag(start_flag), .finish_flag(finish_flag), .full(full),
    .empty(empty), .count(count), .busy(busy), .done(done), .wr_err(wr_err), .err(err)
  );

  always #5 clk = ~clk;

  // morse_send stand-in: drop finish one cycle after start, raise it after play_len cycles.
  initial begin : send_model
    finish_flag = 1'b1;
    forever begin
      @(posedge start_flag);
      @(posedge clk);
      #1 finish_flag = 1'b0;
      repeat (play_len) @(posedge clk);
      while (hold_low) @(posedge clk);
      #1 finish_flag = 1'b1;
    end
  end

  initial begin : start_mon
    logic       fin_at_rise;
    logic [7:0] e;
    int         len;
    forever begin
      @(posedge start_flag);
      fin_at_rise = finish_flag;
      #1;
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: start_flag rose with val=%0d, none expected", val);
      end else begin
        e = exp_q.pop_front();
        if (val !== e) begin
          errors++;
          $display("FAIL start_val: val=%0d expected %0d", val, e);
        end
        if (e != 8'hFF) begin
          checks++;
          if (fin_at_rise !== 1'b1) begin
            errors++;
            $display("FAIL start_before_finish: finish_flag=%b at start, expected 1", fin_at_rise);
          end
        end
      end
      len = 0;
      while (start_flag === 1'b1 && len < 50) begin
        len++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (len != START_LEN) begin
        errors++;
        $display("FAIL start_len: start_flag high %0d cycles, expected %0d", len, START_LEN);
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1)  err_cnt++;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] code, input bit expect_play);
    wr_en   = 1'b1;
    wr_data = code;
    if (expect_play) exp_q.push_back(code);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; clear = 1'b0;
    repeat (3) tick();
    checks++;
    if (val !== 8'hFF) begin errors++; $display("FAIL reset_val: val=%0h expected ff", val); end
    checks++;
    if (start_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: start=%b busy=%b done=%b expected 0 0 0", start_flag, busy, done);
    end
    checks++;
    if (err !== 1'b0 || wr_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: err=%b wr_err=%b expected 0 0", err, wr_err);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL reset_fifo: empty=%b full=%b count=%0d expected 1 0 0", empty, full, count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_playback();
    int d0, s0, n;
    d0 = done_cnt; s0 = start_cnt;
    push(8'd3, 1'b1); push(8'd65, 1'b1); push(8'd9, 1'b1);
    checks++;
    if (count !== 5'd3) begin errors++; $display("FAIL play_count_in: count=%0d expected 3", count); end
    send = 1'b1;
    tick();                       // E0: send sampled, LOAD
    send = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL play_busy: busy=%b expected 1", busy); end
    tick();                       // E1: val loaded, start_flag not yet
    checks++;
    if (val !== 8'd3 || start_flag !== 1'b0) begin
      errors++; $display("FAIL play_e1: val=%0d start=%b expected 3 0", val, start_flag);
    end
    tick();                       // E2: start_flag rises
    checks++;
    if (start_flag !== 1'b1) begin errors++; $display("FAIL play_e2: start=%b expected 1", start_flag); end
    wait_idle(n);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL play_idle: busy=%b after %0d cycles, expected 0", busy, n); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL play_done: %0d done pulses expected 1", done_cnt - d0); end
    checks++;
    if (start_cnt - s0 != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL play_starts: %0d starts, %0d left expected 3 0", start_cnt - s0, exp_q.size());
    end
    checks++;
    if (count !== 5'd0) begin errors++; $display("FAIL play_count_out: count=%0d expected 0", count); end
  endtask

  task automatic test_wr_reject();
    logic [7:0] codes [16];
    codes = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
              8'd8, 8'd9, 8'd65, 8'd66, 8'd255, 8'd1, 8'd2, 8'd3};
    push(8'd10, 1'b0);
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL rej_10: wr_err=%b expected 1", wr_err); end
    push(8'd200, 1'b0);
    checks++;
    if (wr_err !== 1'b1) begin errors++; $display("FAIL rej_200: wr_err=%b expected 1", wr_err); end
    tick();
    checks++;
    if (wr_err !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL rej_after: wr_err=%b count=%0d expected 0 0", wr_err, count);
    end
    for (int i = 0; i < 16; i++) push(codes[i], 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || wr_err !== 1'b0) begin
      errors++; $display("FAIL fill16: full=%b count=%0d wr_err=%b expected 1 16 0", full, count, wr_err);
    end
    push(8'd66, 1'b0);
    checks++;
    if (wr_err !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL rej_full: wr_err=%b count=%0d expected 1 16", wr_err, count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_idle: count=%0d empty=%b busy=%b expected 0 1 0", count, empty, busy);
    end
  endtask

  task automatic test_send_empty();
    int s0;
    s0 = start_cnt;
    send = 1'b1;
    tick();
    send = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL empty_done: done=%b expected 1", done); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_after: done=%b busy=%b expected 0 0", done, busy);
    end
    repeat (5) tick();
    checks++;
    if (start_cnt != s0) begin errors++; $display("FAIL empty_start: %0d starts expected 0", start_cnt - s0); end
  endtask

  task automatic test_clear_abort();
    int d0, s0, n;
    d0 = done_cnt; s0 = start_cnt;
    push(8'd1, 1'b1); push(8'd2, 1'b1); push(8'd3, 1'b1); push(8'd4, 1'b1);
    send = 1'b1;
    tick();
    send = 1'b0;
    n = 0;
    while (start_cnt < s0 + 2 && n < 2000) begin tick(); n++; end
    checks++;
    if (start_cnt < s0 + 2) begin errors++; $display("FAIL abort_reach: %0d starts expected 2", start_cnt - s0); end
    repeat (5) tick();            // start pulse over, finish low: waiting for finish
    exp_q.delete();
    exp_q.push_back(8'hFF);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (count !== 5'd0 || val !== 8'hFF) begin
      errors++; $display("FAIL abort_now: count=%0d val=%0h expected 0 ff", count, val);
    end
    wait_idle(n);
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      errors++; $display("FAIL abort_end: busy=%b done pulses=%0d expected 0 0", busy, done_cnt - d0);
    end
    checks++;
    if (start_cnt != s0 + 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_pulse: %0d starts, %0d left expected 3 0", start_cnt - s0, exp_q.size());
    end
    n = 0;
    while (finish_flag !== 1'b1 && n < 200) begin tick(); n++; end
  endtask

  task automatic test_timeout();
    int d0, e0, n;
    d0 = done_cnt; e0 = err_cnt;
    hold_low = 1'b1;
    push(8'd5, 1'b1); push(8'd6, 1'b1);
    send = 1'b1;
    tick();
    send = 1'b0;
    n = 0;
    while (start_flag !== 1'b1 && n < 50) begin tick(); n++; end
    n = 0;
    while (err !== 1'b1 && n < 400) begin tick(); n++; end
    // WAIT_FIN begins START_LEN-1 edges after start_flag rises; err follows TIMEOUT edges later.
    checks++;
    if (n != TIMEOUT + START_LEN - 1) begin
      errors++; $display("FAIL timeout_delay: err after %0d cycles expected %0d", n, TIMEOUT + START_LEN - 1);
    end
    hold_low = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_pulse: err=%b expected 0", err); end
    wait_idle(n);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL timeout_end: err pulses=%0d done pulses=%0d expected 1 1", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_next: %0d codes unplayed expected 0", exp_q.size()); end
  endtask

  task automatic test_push_pop_and_reset();
    int s0, n;
    s0 = start_cnt;
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    checks++;
    if (count !== 5'd5) begin errors++; $display("FAIL pp_pre: count=%0d expected 5", count); end
    send = 1'b1;
    tick();                       // E0: LOAD
    send = 1'b0;
    wr_en = 1'b1; wr_data = 8'd66; exp_q.push_back(8'd66);
    tick();                       // E1: pop and push together
    wr_en = 1'b0;
    checks++;
    if (count !== 5'd5 || wr_err !== 1'b0) begin
      errors++; $display("FAIL pp_same: count=%0d wr_err=%b expected 5 0", count, wr_err);
    end
    n = 0;
    while (start_cnt < s0 + 2 && n < 2000) begin tick(); n++; end
    n = 0;
    while (finish_flag !== 1'b0 && n < 50) begin tick(); n++; end
    n = 0;
    while (finish_flag !== 1'b1 && n < 200) begin tick(); n++; end
    repeat (6) tick();            // past the synchronizer, inside the gap
    rst = 1'b1;
    tick();
    checks++;
    if (val !== 8'hFF || start_flag !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_gap_ctl: val=%0h start=%b busy=%b done=%b expected ff 0 0 0", val, start_flag, busy, done);
    end
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || err !== 1'b0 || wr_err !== 1'b0) begin
      errors++; $display("FAIL rst_gap_fifo: count=%0d empty=%b full=%b err=%b wr_err=%b expected 0 1 0 0 0",
                         count, empty, full, err, wr_err);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (30) tick();
    checks++;
    if (busy !== 1'b0 || start_cnt != s0 + 2) begin
      errors++; $display("FAIL rst_gap_idle: busy=%b starts=%0d expected 0 2", busy, start_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_wr_reject();
    test_send_empty();
    test_clear_abort();
    test_timeout();
    test_push_pop_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
